timer_multi: RTL and testbench

Parametrised multi-channel timer replacing the single fixed timer that drives `timer_interrupt` into the CSR trap path of the RV32 processor. It provides NUM_CH independent counters behind one shared prescaler, each with a compare register and one-shot or periodic mode. It exposes a memory-mapped register port sharing the data-memory address and write-data path, and it produces one combined interrupt line plus the index of the lowest pending source.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/timer_channel.sv | 57 +++++
 rtl/timer_multi.sv | 128 ++++++++++++
 tb/tb_timer_multi.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel timer: register map, CFG bit
// positions and the channel-count ceiling.
package timer_pkg;

    localparam int MAX_CH = 8;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_IE     = 8'h04;
    localparam logic [7:0] ADDR_IP     = 8'h08;
    localparam logic [7:0] ADDR_IRQ_ID = 8'h0C;

    localparam logic [7:0] CH_BASE   = 8'h10;
    localparam logic [7:0] CH_STRIDE = 8'h10;
    localparam logic [7:0] OFF_CFG   = 8'h00;
    localparam logic [7:0] OFF_COUNT = 8'h04;
    localparam logic [7:0] OFF_CMP   = 8'h08;

    localparam int CFG_EN_BIT  = 0;
    localparam int CFG_PER_BIT = 1;

    // Word-aligned byte address of register `off` inside channel `ch`.
    function automatic logic [7:0] ch_addr(input int ch, input logic [7:0] off);
        return 8'(int'(CH_BASE) + int'(CH_STRIDE) * ch + int'(off));
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: COUNT/CMP/EN/PERIODIC state, advancing on prescaler ticks
// and emitting a one-cycle match pulse when COUNT equals CMP.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             cfg_we,
    input  logic             count_we,
    input  logic             cmp_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             match,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] cmp,
    output logic             en,
    output logic             periodic
);

    logic active;

    // A software write to COUNT or CFG owns the channel for this cycle.
    assign active = tick && en && !cfg_we && !count_we;
    assign match  = active && (count == cmp);

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            cmp      <= '0;
            en       <= 1'b0;
            periodic <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
            end else if (match) begin
                count <= '0;
            end else if (active) begin
                count <= count + WIDTH'(1);
            end

            if (cmp_we) begin
                cmp <= wdata;
            end

            if (cfg_we) begin
                en       <= wdata[CFG_EN_BIT];
                periodic <= wdata[CFG_PER_BIT];
            end else if (match && !periodic) begin
                en <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer: shared prescaler, NUM_CH compare channels, IE/IP with
// write-one-to-clear, memory-mapped register port and lowest-index IRQ encoder.
module timer_multi
    import timer_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int PRE_W  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [2:0]  irq_id
);

    logic [7:0]        word;
    logic              unused_bits;
    logic              gen;
    logic [PRE_W-1:0]  prescale;
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic [NUM_CH-1:0] ie;
    logic [NUM_CH-1:0] ip;
    logic [NUM_CH-1:0] ip_clr;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] match_vec;
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] per_q;
    logic [WIDTH-1:0]  count_q [NUM_CH];
    logic [WIDTH-1:0]  cmp_q   [NUM_CH];

    assign word        = {addr[7:2], 2'b00};
    assign unused_bits = ^{addr[1:0], wdata};

    assign tick   = gen && (pre_cnt == prescale);
    assign ip_clr = (wr_en && word == ADDR_IP) ? wdata[NUM_CH-1:0] : '0;
    assign pend   = ip & ie;
    assign irq    = |pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen      <= 1'b0;
            prescale <= '0;
            pre_cnt  <= '0;
            ie       <= '0;
            ip       <= '0;
        end else begin
            if (!gen || pre_cnt == prescale) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end

            if (wr_en && word == ADDR_CTRL) begin
                gen      <= wdata[0];
                prescale <= wdata[8 +: PRE_W];
            end

            if (wr_en && word == ADDR_IE) begin
                ie <= wdata[NUM_CH-1:0];
            end

            // A hardware set on the same edge as a software clear wins.
            ip <= (ip & ~ip_clr) | match_vec;
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .cfg_we   (wr_en && word == ch_addr(n, OFF_CFG)),
            .count_we (wr_en && word == ch_addr(n, OFF_COUNT)),
            .cmp_we   (wr_en && word == ch_addr(n, OFF_CMP)),
            .wdata    (wdata[WIDTH-1:0]),
            .match    (match_vec[n]),
            .count    (count_q[n]),
            .cmp      (cmp_q[n]),
            .en       (en_q[n]),
            .periodic (per_q[n])
        );
    end

    always_comb begin
        irq_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                irq_id = 3'(i);
            end
        end
    end

    // NOTE: rdata gets its default first so no path through this block infers a latch.
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            if (word == ADDR_CTRL) begin
                rdata[0]          = gen;
                rdata[8 +: PRE_W] = prescale;
            end else if (word == ADDR_IE) begin
                rdata[NUM_CH-1:0] = ie;
            end else if (word == ADDR_IP) begin
                rdata[NUM_CH-1:0] = ip;
            end else if (word == ADDR_IRQ_ID) begin
                rdata[2:0] = irq_id;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (word == ch_addr(i, OFF_CFG)) begin
                    rdata[CFG_EN_BIT]  = en_q[i];
                    rdata[CFG_PER_BIT] = per_q[i];
                end else if (word == ch_addr(i, OFF_COUNT)) begin
                    rdata[WIDTH-1:0] = count_q[i];
                end else if (word == ch_addr(i, OFF_CMP)) begin
                    rdata[WIDTH-1:0] = cmp_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi (8-bit counters, 4 channels): directed
// register-level scenarios plus a per-cycle comparison against a behavioural model.
module tb_timer_multi;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rdata;
    logic        irq;
    logic [2:0]  irq_id;

    int n_checks = 0;
    int n_fail   = 0;

    timer_multi #(
        .WIDTH  (8),
        .NUM_CH (NCH),
        .PRE_W  (8)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wdata  (wdata),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .rdata  (rdata),
        .irq    (irq),
        .irq_id (irq_id)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integers updated once per rising edge.
    int m_cnt [NCH];
    int m_cmp [NCH];
    bit m_en  [NCH];
    bit m_per [NCH];
    int m_ie = 0, m_ip = 0, m_ps = 0, m_pre = 0;
    bit m_gen = 1'b0;

    task automatic model_clear();
        for (int n = 0; n < NCH; n++) begin
            m_cnt[n] = 0; m_cmp[n] = 0; m_en[n] = 1'b0; m_per[n] = 1'b0;
        end
        m_ie = 0; m_ip = 0; m_ps = 0; m_pre = 0; m_gen = 1'b0;
    endtask

    initial model_clear();

    always @(posedge clk or negedge rst) begin : model
        int a, hit, clr, ch, off;
        bit tk, sw;
        if (!rst) begin
            model_clear();
        end else begin
            a   = int'(addr) & 'hFC;
            tk  = m_gen && (m_pre == m_ps);
            hit = 0;
            clr = 0;
            for (int n = 0; n < NCH; n++) begin
                sw = wr_en && (a == 16 * (n + 1) || a == 16 * (n + 1) + 4);
                if (tk && m_en[n] && !sw) begin
                    if (m_cnt[n] == m_cmp[n]) begin
                        hit |= (1 << n);
                        m_cnt[n] = 0;
                        if (!m_per[n]) m_en[n] = 1'b0;
                    end else begin
                        m_cnt[n] = (m_cnt[n] + 1) % 256;
                    end
                end
            end
            if (!m_gen || tk) m_pre = 0;
            else m_pre = m_pre + 1;
            if (wr_en) begin
                if (a == 0) begin
                    m_gen = wdata[0];
                    m_ps  = int'(wdata[15:8]);
                end else if (a == 4) begin
                    m_ie = int'(wdata[3:0]);
                end else if (a == 8) begin
                    clr = int'(wdata[3:0]);
                end else if (a >= 16 && a < 16 * (NCH + 1)) begin
                    ch  = a / 16 - 1;
                    off = a % 16;
                    if (off == 0) begin
                        m_en[ch]  = wdata[0];
                        m_per[ch] = wdata[1];
                    end else if (off == 4) begin
                        m_cnt[ch] = int'(wdata[7:0]);
                    end else if (off == 8) begin
                        m_cmp[ch] = int'(wdata[7:0]);
                    end
                end
            end
            m_ip = (m_ip & ~clr) | hit;
        end
    end

    function automatic int exp_id();
        for (int i = 0; i < NCH; i++) begin
            if (((m_ip & m_ie) >> i) & 1) return i;
        end
        return 0;
    endfunction

    function automatic int exp_rd(input bit re, input logic [7:0] ad);
        int a, ch, off;
        a = int'(ad) & 'hFC;
        if (!re) return 0;
        if (a == 0) return (m_ps << 8) | int'(m_gen);
        if (a == 4) return m_ie;
        if (a == 8) return m_ip;
        if (a == 12) return exp_id();
        if (a >= 16 && a < 16 * (NCH + 1)) begin
            ch  = a / 16 - 1;
            off = a % 16;
            if (off == 0) return int'(m_en[ch]) | (int'(m_per[ch]) << 1);
            if (off == 4) return m_cnt[ch];
            if (off == 8) return m_cmp[ch];
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        check("cyc_irq", 32'(irq), 32'((m_ip & m_ie) != 0));
        check("cyc_irq_id", 32'(irq_id), 32'(exp_id()));
        check("cyc_rdata", rdata, 32'(exp_rd(rd_en, addr)));
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(posedge clk);
        #2;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
        rd_en = 1'b1;
        addr  = a;
        #1;
        check(name, rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1'b0;
        #2;
        rd_check("rst_count0", 8'h14, 0);
        rd_check("rst_ctrl", 8'h00, 0);
        check("rst_irq", 32'(irq), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle(1);

        // Basic one-shot match on the 6th tick after enable.
        wr(8'h00, 32'h1);
        wr(8'h18, 32'd5);
        wr(8'h04, 32'h1);
        wr(8'h10, 32'h1);
        idle(5);
        rd_check("t1_ip_before", 8'h08, 0);
        check("t1_irq_before", 32'(irq), 0);
        idle(1);
        rd_check("t1_ip", 8'h08, 1);
        check("t1_irq", 32'(irq), 1);
        rd_check("t1_count0", 8'h14, 0);
        rd_check("t1_cfg0", 8'h10, 0);

        // One-shot with CMP0=1: disables itself and stays at 0.
        wr(8'h18, 32'd1);
        wr(8'h08, 32'h1);
        wr(8'h10, 32'h1);
        idle(2);
        rd_check("t3_ip", 8'h08, 1);
        rd_check("t3_cfg0", 8'h10, 0);
        rd_check("t3_count0", 8'h14, 0);
        wr(8'h08, 32'h1);
        idle(5);
        rd_check("t3_no_reip", 8'h08, 0);
        rd_check("t3_count_hold", 8'h14, 0);

        // Periodic channel 1, PRESCALE=3, CMP1=2: 12-cycle period.
        wr(8'h00, 32'h301);
        wr(8'h28, 32'd2);
        wr(8'h20, 32'h3);
        idle(9);
        rd_check("t2_ip_pre", 8'h08, 0);
        idle(1);
        rd_check("t2_ip_set", 8'h08, 2);
        wr(8'h08, 32'h2);
        rd_check("t2_ip_clr", 8'h08, 0);
        idle(10);
        rd_check("t2_ip_still0", 8'h08, 0);
        idle(1);
        rd_check("t2_ip_reset", 8'h08, 2);
        rd_check("t2_cfg1", 8'h20, 3);

        // Channels 2 and 3 pending: priority and masking.
        wr(8'h20, 32'h0);
        wr(8'h08, 32'hF);
        wr(8'h38, 32'd0);
        wr(8'h48, 32'd0);
        wr(8'h04, 32'hC);
        wr(8'h30, 32'h1);
        wr(8'h40, 32'h1);
        idle(8);
        rd_check("t4_ip", 8'h08, 32'hC);
        rd_check("t4_idreg", 8'h0C, 2);
        check("t4_irq_id", 32'(irq_id), 2);
        check("t4_irq", 32'(irq), 1);
        wr(8'h08, 32'h4);
        check("t4_irq_id3", 32'(irq_id), 3);
        rd_check("t4_ip8", 8'h08, 8);
        wr(8'h04, 32'h0);
        check("t4_irq_masked", 32'(irq), 0);
        check("t4_irq_id_masked", 32'(irq_id), 0);
        rd_check("t4_ip_kept", 8'h08, 8);

        // Set-wins on W1C collision; COUNT write beats a tick.
        wr(8'h00, 32'h0);
        wr(8'h00, 32'h1);
        wr(8'h04, 32'h1);
        wr(8'h08, 32'hF);
        wr(8'h18, 32'd3);
        wr(8'h14, 32'd0);
        wr(8'h10, 32'h3);
        idle(3);
        wr(8'h08, 32'h1);
        rd_check("t5_set_wins", 8'h08, 1);
        check("t5_irq", 32'(irq), 1);
        wr(8'h14, 32'd7);
        rd_check("t5_count7", 8'h14, 7);
        wr(8'h10, 32'h0);
        rd_check("t5_count_cfgwin", 8'h14, 7);

        // 8-bit wrap-around does not raise IP; later match does.
        wr(8'h08, 32'hF);
        wr(8'h18, 32'h05);
        wr(8'h14, 32'hFE);
        wr(8'h10, 32'h1);
        idle(2);
        rd_check("t6_wrap", 8'h14, 0);
        rd_check("t6_no_ip", 8'h08, 0);
        idle(5);
        rd_check("t6_count5", 8'h14, 5);
        idle(1);
        rd_check("t6_match_ip", 8'h08, 1);
        rd_check("t6_count0", 8'h14, 0);

        // GEN=0 freezes counting; then asynchronous reset mid-count.
        wr(8'h08, 32'hF);
        wr(8'h18, 32'd200);
        wr(8'h10, 32'h3);
        idle(4);
        wr(8'h00, 32'h0);
        idle(3);
        rd_check("gen_freeze", 8'h14, 5);
        wr(8'h00, 32'h1);
        idle(2);
        rd_check("gen_resume", 8'h14, 7);
        #1 rst = 1'b0;
        rd_check("arst_count0", 8'h14, 0);
        rd_check("arst_ctrl", 8'h00, 0);
        check("arst_irq", 32'(irq), 0);
        check("arst_irq_id", 32'(irq_id), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // First tick after release comes PRESCALE+1 cycles after GEN is set.
        wr(8'h10, 32'h1);
        wr(8'h04, 32'h1);
        wr(8'h00, 32'h201);
        idle(2);
        rd_check("rel_ip_pre", 8'h08, 0);
        idle(1);
        rd_check("rel_ip", 8'h08, 1);
        check("rel_irq", 32'(irq), 1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
